// File: rtl/rotation_sweep_ctrl.sv
// rotation_sweep_ctrl
//   Sequencer for the sin/cos rotation wave generator. Steps the generator's
//   paso input from a start value to a stop value, holding each value for a
//   programmed number of whole wave periods.
//
//   Paso changes only on period boundaries. Each change is accompanied by a
//   one-cycle generator reset, so the quarter-wave counters never see a step
//   change in the middle of a period.
//
// Ports
//   clock          system clock
//   i_reset        synchronous, active-high reset
//   i_start        start pulse, sampled only in IDLE
//   i_abort        abort request, honoured in LOAD/RUN/NEXT
//   i_loop         restart from i_paso_start after the last step (sampled at start)
//   i_paso_start   first paso value (sampled at start)
//   i_paso_stop    last paso value (sampled at start)
//   i_dwell        periods per step, 0 treated as 1 (sampled at start)
//   i_sample_en    sample-rate strobe
//   o_wave_reset   generator reset pulse (registered)
//   o_wave_enable  generator enable (combinational: RUN and i_sample_en)
//   o_paso         generator step select (registered)
//   o_busy         sweep in progress (registered)
//   o_period_end   last sample of a period (combinational)
//   o_done         sweep-complete pulse (registered)
//   o_err          config-error pulse (registered)
module rotation_sweep_ctrl #(
   parameter int PASO_MAX    = 10,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic                   i_loop,
   input  logic [3:0]             i_paso_start,
   input  logic [3:0]             i_paso_stop,
   input  logic [DWELL_WIDTH-1:0] i_dwell,
   input  logic                   i_sample_en,
   output logic                   o_wave_reset,
   output logic                   o_wave_enable,
   output logic [3:0]             o_paso,
   output logic                   o_busy,
   output logic                   o_period_end,
   output logic                   o_done,
   output logic                   o_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      NEXT  = 3'd3,
      FLUSH = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [3:0] PASO_LIMIT = 4'(PASO_MAX);

   state_t                 state;
   logic [11:0]            sample_cnt;
   logic [DWELL_WIDTH-1:0] period_cnt;
   logic [DWELL_WIDTH-1:0] dwell_eff;
   logic [3:0]             paso_start;
   logic [3:0]             paso_stop;
   logic                   loop_mode;
   logic                   step_down;

   logic                   sample_last;
   logic                   dwell_last;
   logic                   cfg_bad;

   // The period of paso p is (4095>>p)+1 samples; the counter wraps at 4095>>p.
   assign sample_last   = (sample_cnt == (12'hFFF >> o_paso));
   // Checked only on a period end: this period completes the dwell.
   assign dwell_last    = ((period_cnt + DWELL_WIDTH'(1)) == dwell_eff);
   assign cfg_bad       = (i_paso_start > PASO_LIMIT) || (i_paso_stop > PASO_LIMIT);

   assign o_wave_enable = (state == RUN) && i_sample_en;
   assign o_period_end  = (state == RUN) && i_sample_en && sample_last;

   // Sweep sequencer: state, counters, latched config and registered outputs.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state        <= IDLE;
         sample_cnt   <= 12'd0;
         period_cnt   <= '0;
         dwell_eff    <= '0;
         paso_start   <= 4'd0;
         paso_stop    <= 4'd0;
         loop_mode    <= 1'b0;
         step_down    <= 1'b0;
         o_paso       <= 4'd0;
         o_wave_reset <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         // Pulse outputs default low; each transition below raises what it needs.
         o_wave_reset <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (cfg_bad) begin
                     o_err <= 1'b1;
                  end else begin
                     paso_start   <= i_paso_start;
                     paso_stop    <= i_paso_stop;
                     loop_mode    <= i_loop;
                     step_down    <= (i_paso_stop < i_paso_start);
                     dwell_eff    <= (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
                     o_paso       <= i_paso_start;
                     sample_cnt   <= 12'd0;
                     period_cnt   <= '0;
                     o_wave_reset <= 1'b1;
                     o_busy       <= 1'b1;
                     state        <= LOAD;
                  end
               end
            end
            LOAD, NEXT: begin
               sample_cnt <= 12'd0;
               period_cnt <= '0;
               if (i_abort) begin
                  o_wave_reset <= 1'b1;
                  state        <= FLUSH;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               // Abort wins over a same-cycle period end or dwell completion.
               if (i_abort) begin
                  o_wave_reset <= 1'b1;
                  state        <= FLUSH;
               end else if (i_sample_en) begin
                  if (sample_last) begin
                     sample_cnt <= 12'd0;
                     if (dwell_last) begin
                        period_cnt <= '0;
                        if (o_paso != paso_stop) begin
                           o_paso       <= step_down ? (o_paso - 4'd1) : (o_paso + 4'd1);
                           o_wave_reset <= 1'b1;
                           state        <= NEXT;
                        end else if (loop_mode) begin
                           o_paso       <= paso_start;
                           o_wave_reset <= 1'b1;
                           state        <= NEXT;
                        end else begin
                           o_done <= 1'b1;
                           o_busy <= 1'b0;
                           state  <= DONE;
                        end
                     end else begin
                        period_cnt <= period_cnt + DWELL_WIDTH'(1);
                     end
                  end else begin
                     sample_cnt <= sample_cnt + 12'd1;
                  end
               end
            end
            FLUSH: begin
               sample_cnt <= 12'd0;
               period_cnt <= '0;
               o_busy     <= 1'b0;
               state      <= IDLE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotation_sweep_ctrl.sv
module tb_rotation_sweep_ctrl;

   logic        clock = 1'b0;
   logic        i_reset, i_start, i_abort, i_loop, i_sample_en;
   logic [3:0]  i_paso_start, i_paso_stop;
   logic [15:0] i_dwell;
   logic        o_wave_reset, o_wave_enable, o_busy, o_period_end, o_done, o_err;
   logic [3:0]  o_paso;

   rotation_sweep_ctrl #(.PASO_MAX(10), .DWELL_WIDTH(16)) dut (
      .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
      .i_loop(i_loop), .i_paso_start(i_paso_start), .i_paso_stop(i_paso_stop),
      .i_dwell(i_dwell), .i_sample_en(i_sample_en),
      .o_wave_reset(o_wave_reset), .o_wave_enable(o_wave_enable), .o_paso(o_paso),
      .o_busy(o_busy), .o_period_end(o_period_end), .o_done(o_done), .o_err(o_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       start;
      logic       en;
      logic       wr;
      logic       we;
      logic       pe;
      logic       busy;
      logic       done;
      logic [3:0] paso;
   } vec_t;

   vec_t tbl[12];

   int checks = 0;
   int failures = 0;

   // results gathered by run_sweep
   int seg_paso[16];
   int seg_len[16];
   int nseg, n_reset, n_done, n_err, n_pend, n_en, busy_seen, en_at_pend, timed_out;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int s, input int e, input int d, input bit lp);
      i_paso_start = 4'(s);
      i_paso_stop  = 4'(e);
      i_dwell      = 16'(d);
      i_loop       = lp;
   endtask

   // Pulse start then watch outputs each cycle (sampled 1 time unit after
   // the negedge). Returns on o_done, on the budget, when n_en reaches
   // stop_en, or when nseg reaches stop_seg (0 disables those two).
   task automatic run_sweep(input int budget, input bit toggle, input int stop_en,
                            input int stop_seg, input bit stop_on_done);
      nseg = 0; n_reset = 0; n_done = 0; n_err = 0; n_pend = 0; n_en = 0;
      busy_seen = 0; en_at_pend = 0; timed_out = 1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clock);
         i_start     = (k == 0);
         i_sample_en = toggle ? 1'((k % 2) == 1) : 1'b1;
         #1;
         if (o_wave_reset) begin
            n_reset++;
            if (nseg < 16) begin
               seg_paso[nseg] = int'(o_paso);
               seg_len[nseg]  = 0;
               nseg++;
            end
         end
         if (o_wave_enable) begin
            n_en++;
            if (nseg > 0) seg_len[nseg-1]++;
         end
         if (o_period_end) begin
            n_pend++;
            if (n_pend == 1) en_at_pend = n_en;
         end
         if (o_busy) busy_seen++;
         if (o_err) n_err++;
         if (o_done) n_done++;
         if ((o_done && stop_on_done) || (stop_en != 0 && n_en == stop_en) ||
             (stop_seg != 0 && nseg == stop_seg)) begin
            timed_out = 0;
            break;
         end
      end
      i_start = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_sample_en = 1'b0;
      set_cfg(0, 0, 0, 1'b0);

      // Trace for start=stop=10, dwell=2: LOAD at 1, 8 samples 2..9,
      // period ends at 5 and 9, done at 10.
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10};
      for (int i = 2; i <= 9; i++)
         tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'((i == 5) || (i == 9)), 1'b1, 1'b0, 4'd10};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10};

      repeat (2) @(posedge clock);
      @(negedge clock);
      i_reset = 1'b0;
      #1;
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_paso", int'(o_paso), 0);
      chk("reset_wave_reset", int'(o_wave_reset), 0);
      chk("reset_done_err", int'({o_done, o_err}), 0);

      set_cfg(10, 10, 2, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         i_start     = tbl[i].start;
         i_sample_en = tbl[i].en;
         #1;
         chk($sformatf("tbl%0d_wave_reset", i), int'(o_wave_reset), int'(tbl[i].wr));
         chk($sformatf("tbl%0d_wave_enable", i), int'(o_wave_enable), int'(tbl[i].we));
         chk($sformatf("tbl%0d_period_end", i), int'(o_period_end), int'(tbl[i].pe));
         chk($sformatf("tbl%0d_busy", i), int'(o_busy), int'(tbl[i].busy));
         chk($sformatf("tbl%0d_done", i), int'(o_done), int'(tbl[i].done));
         chk($sformatf("tbl%0d_paso", i), int'(o_paso), int'(tbl[i].paso));
      end
      i_start = 1'b0;

      // Up sweep 8..10, dwell 1: runs of 16, 8, 4 samples.
      set_cfg(8, 10, 1, 1'b0);
      run_sweep(200, 1'b0, 0, 0, 1'b1);
      chk("up_timeout", timed_out, 0);
      chk("up_nseg", nseg, 3);
      chk("up_paso0", seg_paso[0], 8);  chk("up_len0", seg_len[0], 16);
      chk("up_paso1", seg_paso[1], 9);  chk("up_len1", seg_len[1], 8);
      chk("up_paso2", seg_paso[2], 10); chk("up_len2", seg_len[2], 4);
      chk("up_resets", n_reset, 3);
      chk("up_done", n_done, 1);
      @(negedge clock); #1;
      chk("up_paso_hold", int'(o_paso), 10);

      // Down sweep 10..9, dwell 0 behaves as 1.
      set_cfg(10, 9, 0, 1'b0);
      run_sweep(200, 1'b0, 0, 0, 1'b1);
      chk("down_timeout", timed_out, 0);
      chk("down_nseg", nseg, 2);
      chk("down_paso0", seg_paso[0], 10); chk("down_len0", seg_len[0], 4);
      chk("down_paso1", seg_paso[1], 9);  chk("down_len1", seg_len[1], 8);
      chk("down_done", n_done, 1);

      // Toggling strobe: period end on the 4th enabled sample only.
      set_cfg(10, 10, 1, 1'b0);
      run_sweep(200, 1'b1, 0, 0, 1'b1);
      chk("tog_timeout", timed_out, 0);
      chk("tog_pend", n_pend, 1);
      chk("tog_en_at_pend", en_at_pend, 4);
      chk("tog_total_en", n_en, 4);
      chk("tog_done", n_done, 1);

      // Illegal start value: error pulse, nothing else.
      set_cfg(11, 5, 1, 1'b0);
      run_sweep(8, 1'b0, 0, 0, 1'b1);
      chk("err_pulse", n_err, 1);
      chk("err_busy", busy_seen, 0);
      chk("err_resets", n_reset, 0);

      // Loop mode 9,10,9,10,... never completes; exit via abort.
      set_cfg(9, 10, 1, 1'b1);
      run_sweep(300, 1'b0, 0, 6, 1'b0);
      chk("loop_timeout", timed_out, 0);
      chk("loop_paso0", seg_paso[0], 9);  chk("loop_len0", seg_len[0], 8);
      chk("loop_paso1", seg_paso[1], 10); chk("loop_len1", seg_len[1], 4);
      chk("loop_paso2", seg_paso[2], 9);  chk("loop_len2", seg_len[2], 8);
      chk("loop_paso3", seg_paso[3], 10); chk("loop_len3", seg_len[3], 4);
      chk("loop_paso5", seg_paso[5], 10);
      chk("loop_done", n_done, 0);
      i_abort = 1'b1;
      @(negedge clock); i_abort = 1'b0;
      @(negedge clock); #1;
      chk("loop_abort_busy", int'(o_busy), 0);

      // Abort on the 3rd sample of a paso=9 run.
      set_cfg(9, 9, 1, 1'b0);
      run_sweep(100, 1'b0, 3, 0, 1'b1);
      chk("abort_timeout", timed_out, 0);
      i_abort = 1'b1;
      @(negedge clock); i_abort = 1'b0; #1;
      chk("flush_wave_reset", int'(o_wave_reset), 1);
      chk("flush_busy", int'(o_busy), 1);
      chk("flush_enable", int'(o_wave_enable), 0);
      chk("flush_done", int'(o_done), 0);
      @(negedge clock); #1;
      chk("post_flush_busy", int'(o_busy), 0);
      chk("post_flush_done", int'(o_done), 0);
      chk("post_flush_wave_reset", int'(o_wave_reset), 0);
      set_cfg(10, 10, 1, 1'b0);
      run_sweep(100, 1'b0, 0, 0, 1'b1);
      chk("restart_nseg", nseg, 1);
      chk("restart_len", seg_len[0], 4);
      chk("restart_done", n_done, 1);

      // Reset in the middle of a sweep returns straight to reset state.
      set_cfg(8, 8, 1, 1'b0);
      run_sweep(100, 1'b0, 5, 0, 1'b1);
      i_reset = 1'b1;
      @(negedge clock); i_reset = 1'b0; #1;
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_paso", int'(o_paso), 0);
      chk("midrst_wave_reset", int'(o_wave_reset), 0);
      chk("midrst_enable", int'(o_wave_enable), 0);
      @(negedge clock); #1;
      chk("midrst_done", int'(o_done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
